// File: rtl/sysray_ws.sv
// sysray_ws: weight-stationary systolic matrix-vector engine, y[c] = sum_r x[r]*W[r][c]
//   clk, rst              clock, asynchronous active-high reset
//   w_valid_i/w_data_i    weight row beat (W[k][c] at c*DATA_W), w_ready_o accepts
//   x_valid_i/x_data_i    input vector (x[r] at r*DATA_W), x_ready_o accepts
//   y_valid_o/y_data_o    aligned output vector (y[c] at c*ACC_W), one beat per vector
//   loaded_o              full weight set resident
module sysray_ws #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_valid_i,
    input  logic [COLS*DATA_W-1:0]  w_data_i,
    output logic                    w_ready_o,
    input  logic                    x_valid_i,
    input  logic [ROWS*DATA_W-1:0]  x_data_i,
    output logic                    x_ready_o,
    output logic                    y_valid_o,
    output logic [COLS*ACC_W-1:0]   y_data_o,
    output logic                    loaded_o
);
    localparam int L  = ROWS + COLS - 1;
    localparam int KW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int NW = $clog2(L + 1);
    typedef enum logic [1:0] {EMPTY, LOAD, ARMED} state_t;
    state_t state;
    logic [KW-1:0] k, wk;
    logic [NW-1:0] inflight;
    logic [L-1:0] vr;
    logic [L:0] sh;
    logic w_acc, x_acc;
    logic signed [DATA_W-1:0] w [ROWS][COLS];
    logic signed [DATA_W-1:0] xin [ROWS][COLS];
    logic signed [ACC_W-1:0] pin [ROWS][COLS];
    logic signed [ACC_W-1:0] bot [COLS];
    logic signed [ACC_W-1:0] dsk [COLS];
    assign w_ready_o = state != ARMED || inflight == '0;
    assign x_ready_o = state == ARMED && !w_valid_i;
    assign loaded_o  = state == ARMED;
    assign w_acc     = w_valid_i && w_ready_o;
    assign x_acc     = x_valid_i && x_ready_o;
    assign wk        = state == LOAD ? k : '0;
    // sh[i] is the accept strobe delayed i cycles; sh[L] is the output valid
    assign sh        = {vr, x_acc};
    assign y_valid_o = sh[L];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            k        <= '0;
            inflight <= '0;
            vr       <= '0;
            y_data_o <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    w[r][c] <= '0;
        end else begin
            if (w_acc) begin
                for (int c = 0; c < COLS; c++)
                    w[wk][c] <= w_data_i[c*DATA_W +: DATA_W];
                state <= wk == KW'(ROWS - 1) ? ARMED : LOAD;
                k     <= wk + 1'b1;
            end
            inflight <= inflight + NW'(x_acc) - NW'(y_valid_o);
            vr       <= sh[L-1:0];
            if (sh[L-1])
                for (int c = 0; c < COLS; c++)
                    y_data_o[c*ACC_W +: ACC_W] <= dsk[c];
        end
    end
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        // row r waits r cycles so each column sees a diagonal wavefront
        if (r == 0) begin : g_s0
            assign xin[0][0] = x_data_i[DATA_W-1:0];
        end else begin : g_skew
            logic signed [DATA_W-1:0] d [r];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < r; i++) d[i] <= '0;
                end else begin
                    d[0] <= x_data_i[r*DATA_W +: DATA_W];
                    for (int i = 1; i < r; i++) d[i] <= d[i-1];
                end
            end
            assign xin[r][0] = d[r-1];
        end
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [2*DATA_W-1:0] p;
            logic signed [ACC_W-1:0] s;
            assign p = (2*DATA_W)'(xin[r][c]) * (2*DATA_W)'(w[r][c]);
            assign s = pin[r][c] + ACC_W'(p);
            if (c < COLS - 1) begin : g_xh
                logic signed [DATA_W-1:0] xh;
                always_ff @(posedge clk or posedge rst)
                    xh <= rst ? '0 : xin[r][c];
                assign xin[r][c+1] = xh;
            end
            // bottom row stays combinational so the output register is the last stage
            if (r < ROWS - 1) begin : g_ps
                logic signed [ACC_W-1:0] ps;
                always_ff @(posedge clk or posedge rst)
                    ps <= rst ? '0 : s;
                assign pin[r+1][c] = ps;
            end else begin : g_bot
                assign bot[c] = s;
            end
        end
    end
    for (genvar c = 0; c < COLS; c++) begin : g_out
        assign pin[0][c] = '0;
        if (c == COLS - 1) begin : g_d0
            assign dsk[c] = bot[c];
        end else begin : g_dsk
            logic signed [ACC_W-1:0] d [COLS-1-c];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < COLS - 1 - c; i++) d[i] <= '0;
                end else begin
                    d[0] <= bot[c];
                    for (int i = 1; i < COLS - 1 - c; i++) d[i] <= d[i-1];
                end
            end
            assign dsk[c] = d[COLS-2-c];
        end
    end
endmodule

// File: tb/tb_sysray_ws.sv
// tb_sysray_ws: directed bench for sysray_ws (4x4, plus a 16-bit accumulator copy)
module tb_sysray_ws;
    logic clk = 0, rst = 1, w_valid = 0, x_valid = 0;
    logic [31:0] w_data = 0, x_data = 0;
    logic w_ready, x_ready, y_valid, loaded;
    logic [127:0] y_data;
    logic w_ready16, x_ready16, y_valid16, loaded16;
    logic [63:0] y16;
    int total = 0, bad = 0, cyc = 0, n;
    logic [127:0] yq[$];
    int tq[$];
    int at[$];
    logic [127:0] id;

    sysray_ws dut (.clk(clk), .rst(rst), .w_valid_i(w_valid), .w_data_i(w_data), .w_ready_o(w_ready),
        .x_valid_i(x_valid), .x_data_i(x_data), .x_ready_o(x_ready), .y_valid_o(y_valid),
        .y_data_o(y_data), .loaded_o(loaded));
    sysray_ws #(.ACC_W(16)) u16 (.clk(clk), .rst(rst), .w_valid_i(w_valid), .w_data_i(w_data),
        .w_ready_o(w_ready16), .x_valid_i(x_valid), .x_data_i(x_data), .x_ready_o(x_ready16),
        .y_valid_o(y_valid16), .y_data_o(y16), .loaded_o(loaded16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (y_valid) begin yq.push_back(y_data); tq.push_back(cyc); end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearq();
        yq.delete();
        tq.delete();
        at.delete();
    endtask

    task automatic load(input logic [127:0] rows);
        for (int k = 0; k < 4; k++) begin
            w_valid = 1;
            w_data = rows[k*32 +: 32];
            #1;
            for (int t = 0; t < 20 && !w_ready; t++) step();
            chk("w_ready_load", 128'(w_ready), 128'(1));
            if (k == 3) chk("loaded_before_last", 128'(loaded), 128'(0));
            step();
        end
        w_valid = 0;
    endtask

    task automatic send(input logic [31:0] x);
        x_valid = 1;
        x_data = x;
        #1 chk("x_ready_send", 128'(x_ready), 128'(1));
        step();
        at.push_back(cyc);
        x_valid = 0;
    endtask

    initial begin
        #2;
        chk("rst_y_valid", 128'(y_valid), 128'(0));
        chk("rst_y_data", y_data, 128'(0));
        chk("rst_loaded", 128'(loaded), 128'(0));
        chk("rst_w_ready", 128'(w_ready), 128'(1));
        chk("rst_x_ready", 128'(x_ready), 128'(0));
        chk("rst16_ready", 128'({w_ready16, x_ready16, y_valid16}), 128'(3'b100));
        step();
        rst = 0;
        // identity
        for (int k = 0; k < 4; k++) id[k*32 +: 32] = 32'(1) << (8 * k);
        load(id);
        chk("id_loaded", 128'(loaded), 128'(1));
        clearq();
        send({8'd4, 8'd3, 8'd2, 8'd1});
        repeat (10) step();
        chk("id_count", 128'(yq.size()), 128'(1));
        chk("id_y", yq[0], {32'd4, 32'd3, 32'd2, 32'd1});
        chk("id_latency", 128'(tq[0] - at[0]), 128'(6));
        chk("id_hold", y_data, {32'd4, 32'd3, 32'd2, 32'd1});
        chk("id_y16", 128'(y16), 128'({16'd4, 16'd3, 16'd2, 16'd1}));
        // signed extreme
        load({16{8'h80}});
        clearq();
        send({4{8'h80}});
        repeat (10) step();
        chk("ext_y", yq[0], {4{32'h0001_0000}});
        chk("ext_y16_wrap", 128'(y16), 128'(0));
        chk("ext_loaded16", 128'(loaded16), 128'(1));
        // streaming
        load({16{8'h01}});
        clearq();
        for (int i = 1; i <= 8; i++) send({4{8'(i)}});
        repeat (10) step();
        chk("str_count", 128'(yq.size()), 128'(8));
        for (int i = 0; i < 8; i++) begin
            chk("str_y", yq[i], {4{32'(4 * (i + 1))}});
            chk("str_lat", 128'(tq[i] - at[i]), 128'(6));
        end
        // gap pattern 1,0,1
        clearq();
        send({4{8'd5}});
        step();
        send({4{8'd6}});
        repeat (10) step();
        chk("gap_count", 128'(yq.size()), 128'(2));
        chk("gap_spacing", 128'(tq[1] - tq[0]), 128'(2));
        chk("gap_y0", yq[0], {4{32'd20}});
        chk("gap_y1", yq[1], {4{32'd24}});
        // reload under traffic
        clearq();
        for (int i = 1; i <= 3; i++) send({4{8'(i)}});
        x_valid = 1;
        x_data = {4{8'd10}};
        w_valid = 1;
        w_data = {4{8'd2}};
        #1;
        chk("rl_x_ready", 128'(x_ready), 128'(0));
        chk("rl_w_ready_busy", 128'(w_ready), 128'(0));
        n = 0;
        while (!w_ready && n < 30) begin step(); n++; end
        chk("rl_w_ready_rise", 128'(w_ready), 128'(1));
        chk("rl_old_count", 128'(yq.size()), 128'(3));
        chk("rl_rise_cycle", 128'(cyc), 128'(tq[2] + 1));
        repeat (4) step();
        w_valid = 0;
        #1 chk("rl_x_ready_armed", 128'(x_ready), 128'(1));
        step();
        at.push_back(cyc);
        x_valid = 0;
        repeat (10) step();
        chk("rl_count", 128'(yq.size()), 128'(4));
        chk("rl_y0", yq[0], {4{32'd4}});
        chk("rl_y1", yq[1], {4{32'd8}});
        chk("rl_y2", yq[2], {4{32'd12}});
        chk("rl_new", yq[3], {4{32'd80}});
        chk("rl_new_lat", 128'(tq[3] - at[3]), 128'(6));
        // weight/vector collision
        clearq();
        w_valid = 1;
        w_data = {4{8'd3}};
        x_valid = 1;
        x_data = {4{8'd1}};
        #1;
        chk("col_x_ready", 128'(x_ready), 128'(0));
        chk("col_w_ready", 128'(w_ready), 128'(1));
        step();
        w_valid = 0;
        #1;
        chk("col_state_load", 128'(loaded), 128'(0));
        chk("col_x_ready_load", 128'(x_ready), 128'(0));
        chk("col_w_ready_load", 128'(w_ready), 128'(1));
        x_valid = 0;
        repeat (10) step();
        chk("col_no_y", 128'(yq.size()), 128'(0));
        w_valid = 1;
        repeat (3) step();
        w_valid = 0;
        #1 chk("col_reloaded", 128'(loaded), 128'(1));
        // reset mid-flight
        clearq();
        send({4{8'd1}});
        repeat (2) step();
        rst = 1;
        #1 chk("mr_y_data", y_data, 128'(0));
        step();
        rst = 0;
        #1;
        chk("mr_loaded", 128'(loaded), 128'(0));
        chk("mr_x_ready", 128'(x_ready), 128'(0));
        chk("mr_w_ready", 128'(w_ready), 128'(1));
        repeat (15) step();
        chk("mr_no_y", 128'(yq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
